// File: rtl/mor1kx_tcm_loader.sv
// Copies a block of 32-bit words from a source Wishbone slave into the TCM.
// Each word is read and then written as a classic single cycle; the CPU is held off the TCM while loading.
module mor1kx_tcm_loader #(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_RETRY = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          src_adr_i,
  input  logic [31:0]          dst_adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          wbm_src_adr_o,
  output logic                 wbm_src_cyc_o,
  output logic                 wbm_src_stb_o,
  output logic                 wbm_src_we_o,
  output logic [3:0]           wbm_src_sel_o,
  output logic [2:0]           wbm_src_cti_o,
  output logic [1:0]           wbm_src_bte_o,
  input  logic [31:0]          wbm_src_dat_i,
  input  logic                 wbm_src_ack_i,
  input  logic                 wbm_src_err_i,
  input  logic                 wbm_src_rty_i,
  output logic [31:0]          wbm_tcm_adr_o,
  output logic                 wbm_tcm_cyc_o,
  output logic                 wbm_tcm_stb_o,
  output logic                 wbm_tcm_we_o,
  output logic [3:0]           wbm_tcm_sel_o,
  output logic [2:0]           wbm_tcm_cti_o,
  output logic [1:0]           wbm_tcm_bte_o,
  output logic [31:0]          wbm_tcm_dat_o,
  input  logic                 wbm_tcm_ack_i,
  input  logic                 wbm_tcm_err_i,
  input  logic                 wbm_tcm_rty_i
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, RD, WR, RTY, DONE} state_t;

  state_t               state;
  state_t               ret_state;
  logic [31:0]          src_adr;
  logic [31:0]          dst_adr;
  logic [31:0]          data;
  logic [LEN_WIDTH-1:0] count;
  logic [RW-1:0]        retry_cnt;
  logic                 err_q;

  // Error beats ack, ack beats retry. The retry that would exceed MAX_RETRY on a beat aborts instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      src_adr   <= '0;
      dst_adr   <= '0;
      data      <= '0;
      count     <= '0;
      retry_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            src_adr   <= src_adr_i;
            dst_adr   <= dst_adr_i;
            count     <= len_i;
            retry_cnt <= '0;
            err_q     <= 1'b0;
            state     <= (len_i == '0) ? DONE : RD;
          end
        end
        RD: begin
          if (wbm_src_err_i) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (wbm_src_ack_i) begin
            data      <= wbm_src_dat_i;
            retry_cnt <= '0;
            state     <= WR;
          end else if (wbm_src_rty_i) begin
            if (retry_cnt == RETRY_LIM) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              ret_state <= RD;
              state     <= RTY;
            end
          end
        end
        WR: begin
          if (wbm_tcm_err_i) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else if (wbm_tcm_ack_i) begin
            src_adr   <= src_adr + 32'd4;
            dst_adr   <= dst_adr + 32'd4;
            count     <= count - LEN_WIDTH'(1);
            retry_cnt <= '0;
            state     <= (count == LEN_WIDTH'(1)) ? DONE : RD;
          end else if (wbm_tcm_rty_i) begin
            if (retry_cnt == RETRY_LIM) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              ret_state <= WR;
              state     <= RTY;
            end
          end
        end
        RTY:     state <= ret_state;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes are pure decodes of the state register, so reset clears them immediately.
  assign busy_o        = (state != IDLE);
  assign cpu_stall_o   = (state != IDLE);
  assign done_o        = (state == DONE);
  assign err_o         = err_q;

  assign wbm_src_adr_o = src_adr;
  assign wbm_src_cyc_o = (state == RD);
  assign wbm_src_stb_o = (state == RD);
  assign wbm_src_we_o  = 1'b0;
  assign wbm_src_sel_o = 4'hF;
  assign wbm_src_cti_o = 3'b000;
  assign wbm_src_bte_o = 2'b00;

  assign wbm_tcm_adr_o = dst_adr;
  assign wbm_tcm_cyc_o = (state == WR);
  assign wbm_tcm_stb_o = (state == WR);
  assign wbm_tcm_we_o  = (state == WR);
  assign wbm_tcm_sel_o = 4'hF;
  assign wbm_tcm_cti_o = 3'b000;
  assign wbm_tcm_bte_o = 2'b00;
  assign wbm_tcm_dat_o = data;

endmodule
